// File: rtl/ps2_kbd.sv
// ps2_kbd: PS/2 set-2 keyboard receiver feeding an Apple-1 style KBD/KBDCR
// register pair. Scancodes are deserialised, translated to uppercase ASCII,
// queued in a small FIFO and polled by the CPU. F1 and F12 raise one-cycle
// clear-screen and reset requests instead of producing characters.
`timescale 1ns/1ps

module ps2_kbd #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 25000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_din,
  input  logic       address,
  input  logic       enable,
  input  logic       r_en,
  output logic [7:0] dout,
  output logic       kbd_ready,
  output logic       clr_screen,
  output logic       reset_req
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } frame_state_t;

  // Synchronisers and glitch filter
  logic          clk_s1, clk_s2, din_s1, din_s2;
  logic          clk_flt;
  logic [FW-1:0] flt_cnt;
  logic          bit_edge;

  // Frame receiver
  frame_state_t  state, state_nxt;
  logic [7:0]    shift_reg;
  logic [2:0]    bit_cnt;
  logic          parity_bit;
  logic [TW-1:0] tmo_cnt;
  logic          frame_ok;
  logic          timed_out;
  logic          code_valid;
  logic [7:0]    code;

  // Decoder
  logic       ext, brk, shift, ctrl;
  logic       is_prefix, is_modifier;
  logic [6:0] lut_char;
  logic       dec_push, dec_clr, dec_rst;
  logic [6:0] dec_char;
  logic       push_valid;
  logic [6:0] push_char;

  // FIFO and CPU interface
  logic [6:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full;
  logic        overrun, seen;
  logic        read_fire, pop, push_ok;

  // Maps a make code to its ASCII character; zero means the key has no mapping.
  function automatic logic [6:0] translate(input logic [7:0] sc, input logic sh);
    logic [6:0] ch;
    ch = 7'h00;
    case (sc)
      8'h1C: ch = 7'h41;  8'h32: ch = 7'h42;  8'h21: ch = 7'h43;
      8'h23: ch = 7'h44;  8'h24: ch = 7'h45;  8'h2B: ch = 7'h46;
      8'h34: ch = 7'h47;  8'h33: ch = 7'h48;  8'h43: ch = 7'h49;
      8'h3B: ch = 7'h4A;  8'h42: ch = 7'h4B;  8'h4B: ch = 7'h4C;
      8'h3A: ch = 7'h4D;  8'h31: ch = 7'h4E;  8'h44: ch = 7'h4F;
      8'h4D: ch = 7'h50;  8'h15: ch = 7'h51;  8'h2D: ch = 7'h52;
      8'h1B: ch = 7'h53;  8'h2C: ch = 7'h54;  8'h3C: ch = 7'h55;
      8'h2A: ch = 7'h56;  8'h1D: ch = 7'h57;  8'h22: ch = 7'h58;
      8'h35: ch = 7'h59;  8'h1A: ch = 7'h5A;
      8'h45: ch = sh ? 7'h29 : 7'h30;
      8'h16: ch = sh ? 7'h21 : 7'h31;
      8'h1E: ch = sh ? 7'h40 : 7'h32;
      8'h26: ch = sh ? 7'h23 : 7'h33;
      8'h25: ch = sh ? 7'h24 : 7'h34;
      8'h2E: ch = sh ? 7'h25 : 7'h35;
      8'h36: ch = sh ? 7'h5E : 7'h36;
      8'h3D: ch = sh ? 7'h26 : 7'h37;
      8'h3E: ch = sh ? 7'h2A : 7'h38;
      8'h46: ch = sh ? 7'h28 : 7'h39;
      8'h0E: ch = sh ? 7'h7E : 7'h60;
      8'h4E: ch = sh ? 7'h5F : 7'h2D;
      8'h55: ch = sh ? 7'h2B : 7'h3D;
      8'h54: ch = sh ? 7'h7B : 7'h5B;
      8'h5B: ch = sh ? 7'h7D : 7'h5D;
      8'h5D: ch = sh ? 7'h7C : 7'h5C;
      8'h4C: ch = sh ? 7'h3A : 7'h3B;
      8'h52: ch = sh ? 7'h22 : 7'h27;
      8'h41: ch = sh ? 7'h3C : 7'h2C;
      8'h49: ch = sh ? 7'h3E : 7'h2E;
      8'h4A: ch = sh ? 7'h3F : 7'h2F;
      8'h29: ch = 7'h20;
      8'h5A: ch = 7'h0D;
      8'h66: ch = 7'h5F;
      8'h76: ch = 7'h1B;
      default: ch = 7'h00;
    endcase
    return ch;
  endfunction

  // Two-stage synchronisers for the asynchronous PS/2 lines; idle level is high.
  always_ff @(posedge clk25) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      din_s1 <= 1'b1;
      din_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      din_s1 <= ps2_din;
      din_s2 <= din_s1;
    end
  end

  // Accept a new PS/2 clock level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk25) begin
    if (rst) begin
      clk_flt <= 1'b1;
      flt_cnt <= '0;
    end else if (clk_s2 == clk_flt) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FLT_LAST) begin
      clk_flt <= clk_s2;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end

  // A bit edge is the cycle in which the filtered clock is about to fall.
  assign bit_edge = clk_flt & ~clk_s2 & (flt_cnt == FLT_LAST);

  // Frame state register.
  always_ff @(posedge clk25) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Frame next-state logic; a stall without bit edges abandons the frame.
  always_comb begin
    state_nxt = state;
    frame_ok  = 1'b0;
    timed_out = (state != S_IDLE) && !bit_edge && (tmo_cnt == TMO_LAST);
    if (timed_out) begin
      state_nxt = S_IDLE;
    end else if (bit_edge) begin
      case (state)
        S_IDLE:   if (!din_s2) state_nxt = S_DATA;
        S_DATA:   if (bit_cnt == 3'd7) state_nxt = S_PARITY;
        S_PARITY: state_nxt = S_STOP;
        S_STOP: begin
          state_nxt = S_IDLE;
          frame_ok  = din_s2 & (^{shift_reg, parity_bit});
        end
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Frame datapath: bit shifting, parity capture, stall timer and scancode register.
  always_ff @(posedge clk25) begin
    if (rst) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
      tmo_cnt    <= '0;
      code_valid <= 1'b0;
      code       <= '0;
    end else begin
      code_valid <= frame_ok;
      if (frame_ok) code <= shift_reg;
      if (state == S_IDLE || bit_edge) tmo_cnt <= '0;
      else                             tmo_cnt <= tmo_cnt + 1'b1;
      if (bit_edge) begin
        case (state)
          S_IDLE:   bit_cnt <= '0;
          S_DATA: begin
            shift_reg <= {din_s2, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 1'b1;
          end
          S_PARITY: parity_bit <= din_s2;
          default:  ;
        endcase
      end
    end
  end

  assign is_prefix   = (code == 8'hE0) || (code == 8'hF0);
  assign is_modifier = (code == 8'h12) || (code == 8'h59) || (code == 8'h14);
  assign lut_char    = translate(code, shift);

  // Decide what a received scancode produces: a character, a pulse, or nothing.
  always_comb begin
    dec_push = 1'b0;
    dec_char = 7'h00;
    dec_clr  = 1'b0;
    dec_rst  = 1'b0;
    if (code_valid && !is_prefix && !is_modifier && !brk) begin
      if (ext) begin
        if (code == 8'h5A) begin
          dec_push = 1'b1;
          dec_char = 7'h0D;
        end
      end else if (code == 8'h05) begin
        dec_clr = 1'b1;
      end else if (code == 8'h07) begin
        dec_rst = 1'b1;
      end else if (lut_char != 7'h00) begin
        dec_push = 1'b1;
        dec_char = (ctrl && lut_char >= 7'h41 && lut_char <= 7'h5A) ?
                   (lut_char & 7'h1F) : lut_char;
      end
    end
  end

  // Prefix and modifier flags, plus the registered push request and pulses.
  always_ff @(posedge clk25) begin
    if (rst) begin
      ext        <= 1'b0;
      brk        <= 1'b0;
      shift      <= 1'b0;
      ctrl       <= 1'b0;
      push_valid <= 1'b0;
      push_char  <= '0;
      clr_screen <= 1'b0;
      reset_req  <= 1'b0;
    end else begin
      push_valid <= dec_push;
      push_char  <= dec_char;
      clr_screen <= dec_clr;
      reset_req  <= dec_rst;
      if (code_valid) begin
        if (code == 8'hE0) begin
          ext <= 1'b1;
        end else if (code == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (code == 8'h12 || code == 8'h59) shift <= ~brk;
          if (code == 8'h14)                  ctrl  <= ~brk;
        end
      end
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign kbd_ready  = ~fifo_empty;
  assign read_fire  = enable & r_en & ~seen;
  assign pop        = read_fire & ~address & ~fifo_empty;
  assign push_ok    = push_valid & (~fifo_full | pop);

  // Character storage; a pop in the same cycle frees the slot being written.
  always_ff @(posedge clk25) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_char;
  end

  // FIFO pointers, sticky overrun and the single-shot read guard.
  always_ff @(posedge clk25) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
      seen    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_valid && !push_ok)   overrun <= 1'b1;
      else if (read_fire && address) overrun <= 1'b0;
      if (read_fire)            seen <= 1'b1;
      else if (!enable && !r_en) seen <= 1'b0;
    end
  end

  // Register read mux presented to the CPU bus.
  always_comb begin
    dout = 8'h00;
    if (address)          dout = {kbd_ready, overrun, 6'b0};
    else if (!fifo_empty) dout = {1'b1, mem[rd_ptr[AW-1:0]]};
  end

endmodule

// File: tb/tb_ps2_kbd.sv
// tb_ps2_kbd: self-checking bench for ps2_kbd. Drives PS/2 frames bit by bit,
// reads the KBD/KBDCR registers like the CPU and compares against constants
// and a table-lookup keyboard model.
`timescale 1ns/1ps

module tb_ps2_kbd;

  localparam int HALF = 12;

  logic       clk25 = 1'b0;
  logic       rst = 1'b1;
  logic       ps2Clk = 1'b1;
  logic       ps2Din = 1'b1;
  logic       address = 1'b0;
  logic       enable = 1'b0;
  logic       rEn = 1'b0;
  logic [7:0] dout;
  logic       kbdReady, clrScreen, resetReq;

  int checks = 0;
  int failures = 0;
  int clrCnt = 0;
  int rstCnt = 0;

  ps2_kbd #(.FILTER_LEN(4), .TIMEOUT(100), .FIFO_DEPTH(4)) dut (
    .clk25(clk25), .rst(rst), .ps2_clk(ps2Clk), .ps2_din(ps2Din),
    .address(address), .enable(enable), .r_en(rEn), .dout(dout),
    .kbd_ready(kbdReady), .clr_screen(clrScreen), .reset_req(resetReq)
  );

  always #5 clk25 = ~clk25;

  // Count high cycles of each pulse output.
  always @(negedge clk25) begin
    if (clrScreen) clrCnt++;
    if (resetReq)  rstCnt++;
  end

  typedef struct packed {
    logic [3:0][7:0] codes;
    logic [2:0]      n;
    logic [7:0]      expDout;
  } vec_t;

  vec_t vecs [12];

  // Keyboard reference tables (US layout)
  logic [7:0] letterCodes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digitCodes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
    8'h3D, 8'h3E, 8'h46};
  logic [7:0] punctCodes [11] = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C,
    8'h52, 8'h41, 8'h49, 8'h4A};
  string digitShift = ")!@#$%^&*(";
  logic [7:0] punctPlain [11] = '{8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B,
    8'h27, 8'h2C, 8'h2E, 8'h2F};
  logic [7:0] punctShift [11] = '{8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A,
    8'h22, 8'h3C, 8'h3E, 8'h3F};

  bit mExt = 0, mBrk = 0, mShift = 0, mCtrl = 0;
  logic [7:0] expQ [$];

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk25);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic ps2Bit(input logic b);
    ps2Din = b;
    waitCycles(HALF);
    ps2Clk = 1'b0;
    waitCycles(HALF);
    ps2Clk = 1'b1;
  endtask

  // Send one frame; optionally corrupt parity/stop or truncate after nBits.
  task automatic sendFrame(input logic [7:0] code, input bit badParity = 0,
                           input bit badStop = 0, input int nBits = 11);
    logic [10:0] frame;
    frame = {~badStop, (~^code) ^ badParity, code, 1'b0};
    for (int i = 0; i < nBits; i++) ps2Bit(frame[i]);
    ps2Din = 1'b1;
    waitCycles(2 * HALF);
  endtask

  task automatic applyStimulus(input logic [7:0] codes [$]);
    foreach (codes[i]) sendFrame(codes[i]);
  endtask

  task automatic cpuRead(input logic a, output logic [7:0] d);
    address = a;
    enable = 1'b1;
    rEn = 1'b1;
    #2;
    d = dout;
    waitCycles(1);
    enable = 1'b0;
    rEn = 1'b0;
    waitCycles(1);
  endtask

  task automatic waitReady(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (kbdReady) begin
        ok = 1;
        break;
      end
      waitCycles(1);
    end
    checkOutput(name, {7'b0, ok}, 8'h01);
  endtask

  // Behavioural keyboard: tracks prefix/modifier state and queues expected reads.
  task automatic modelFeed(input logic [7:0] c);
    bit wasBrk, wasExt;
    int ch;
    if (c == 8'hE0) mExt = 1;
    else if (c == 8'hF0) mBrk = 1;
    else begin
      wasBrk = mBrk;
      wasExt = mExt;
      mBrk = 0;
      mExt = 0;
      ch = -1;
      if (c == 8'h12 || c == 8'h59) mShift = !wasBrk;
      else if (c == 8'h14) mCtrl = !wasBrk;
      else if (!wasBrk) begin
        if (wasExt) begin
          if (c == 8'h5A) ch = 'h0D;
        end else begin
          for (int i = 0; i < 26; i++)
            if (c == letterCodes[i]) ch = mCtrl ? (('h41 + i) & 'h1F) : ('h41 + i);
          for (int i = 0; i < 10; i++)
            if (c == digitCodes[i]) ch = mShift ? int'(digitShift[i]) : ('h30 + i);
          for (int i = 0; i < 11; i++)
            if (c == punctCodes[i]) ch = mShift ? int'(punctShift[i]) : int'(punctPlain[i]);
          if (c == 8'h29) ch = 'h20;
          if (c == 8'h5A) ch = 'h0D;
          if (c == 8'h66) ch = 'h5F;
          if (c == 8'h76) ch = 'h1B;
        end
      end
      if (ch >= 0 && expQ.size() < 4) expQ.push_back(8'h80 | 8'(ch));
    end
  endtask

  logic [7:0] keyPool [] = '{8'h1C, 8'h32, 8'h1A, 8'h45, 8'h16, 8'h1E, 8'h36, 8'h0E,
    8'h4E, 8'h55, 8'h5D, 8'h52, 8'h4A, 8'h29, 8'h5A, 8'h66, 8'h76, 8'h01, 8'h05, 8'h35};

  initial begin
    logic [7:0] d;
    logic [7:0] q [$];
    int c0, r0;

    vecs[0]  = {32'h0000001C, 3'd1, 8'hC1};
    vecs[1]  = {32'h00000029, 3'd1, 8'hA0};
    vecs[2]  = {32'h0000005A, 3'd1, 8'h8D};
    vecs[3]  = {32'h00005AE0, 3'd2, 8'h8D};
    vecs[4]  = {32'h00000066, 3'd1, 8'hDF};
    vecs[5]  = {32'h00000076, 3'd1, 8'h9B};
    vecs[6]  = {32'h12F01612, 3'd4, 8'hA1};
    vecs[7]  = {32'h14F01C14, 3'd4, 8'h81};
    vecs[8]  = {32'h0000004E, 3'd1, 8'hAD};
    vecs[9]  = {32'h59F05259, 3'd4, 8'hA2};
    vecs[10] = {32'h001C75E0, 3'd3, 8'hC1};
    vecs[11] = {32'h00321CF0, 3'd3, 8'hC2};

    waitCycles(3);
    rst = 1'b0;
    waitCycles(2);

    // Reset state
    address = 1'b0; #1;
    checkOutput("reset_kbd", dout, 8'h00);
    address = 1'b1; #1;
    checkOutput("reset_kbdcr", dout, 8'h00);
    checkOutput("reset_ready", {7'b0, kbdReady}, 8'h00);
    checkOutput("reset_pulses", {6'b0, clrScreen, resetReq}, 8'h00);
    waitCycles(1);

    // Make then break of A gives exactly one entry
    q = '{8'h1C, 8'hF0, 8'h1C};
    applyStimulus(q);
    waitReady("a_ready");
    cpuRead(1'b0, d);
    checkOutput("a_read", d, 8'hC1);
    checkOutput("a_empty", {7'b0, kbdReady}, 8'h00);
    cpuRead(1'b0, d);
    checkOutput("a_empty_read", d, 8'h00);

    // Table-driven translations
    for (int v = 0; v < 12; v++) begin
      for (int k = 0; k < int'(vecs[v].n); k++) sendFrame(vecs[v].codes[k]);
      waitReady($sformatf("vec%0d_ready", v));
      cpuRead(1'b0, d);
      checkOutput($sformatf("vec%0d_read", v), d, vecs[v].expDout);
      checkOutput($sformatf("vec%0d_drained", v), {7'b0, kbdReady}, 8'h00);
    end

    // Shift applies only while held
    q = '{8'h12, 8'h16, 8'hF0, 8'h12, 8'h16};
    applyStimulus(q);
    cpuRead(1'b0, d);
    checkOutput("shift_bang", d, 8'hA1);
    cpuRead(1'b0, d);
    checkOutput("shift_one", d, 8'hB1);

    // Bad parity, bad stop, abandoned frame, then a good B
    sendFrame(8'h1C, 1, 0);
    sendFrame(8'h1C, 0, 1);
    sendFrame(8'h21, 0, 0, 4);
    waitCycles(300);
    sendFrame(8'h32);
    waitReady("err_ready");
    cpuRead(1'b0, d);
    checkOutput("err_only_b", d, 8'hC2);
    checkOutput("err_empty", {7'b0, kbdReady}, 8'h00);

    // Overrun: five pushes into a four-deep queue
    q = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
    applyStimulus(q);
    cpuRead(1'b1, d);
    checkOutput("ovr_status", d, 8'hC0);
    cpuRead(1'b1, d);
    checkOutput("ovr_cleared", d, 8'h80);
    for (int i = 0; i < 4; i++) begin
      cpuRead(1'b0, d);
      checkOutput($sformatf("ovr_read%0d", i), d, 8'hC1 + 8'(i));
    end
    checkOutput("ovr_empty", {7'b0, kbdReady}, 8'h00);

    // Held read strobe pops only once
    q = '{8'h1C, 8'h32};
    applyStimulus(q);
    address = 1'b0;
    enable = 1'b1;
    rEn = 1'b1;
    waitCycles(10);
    enable = 1'b0;
    rEn = 1'b0;
    waitCycles(1);
    checkOutput("hold_ready", {7'b0, kbdReady}, 8'h01);
    cpuRead(1'b0, d);
    checkOutput("hold_second", d, 8'hC2);
    checkOutput("hold_empty", {7'b0, kbdReady}, 8'h00);

    // F1 and F12 pulses
    c0 = clrCnt;
    r0 = rstCnt;
    sendFrame(8'h05);
    waitCycles(10);
    checkOutput("f1_clr", 8'(clrCnt - c0), 8'h01);
    checkOutput("f1_rst", 8'(rstCnt - r0), 8'h00);
    sendFrame(8'h07);
    waitCycles(10);
    checkOutput("f12_clr", 8'(clrCnt - c0), 8'h01);
    checkOutput("f12_rst", 8'(rstCnt - r0), 8'h01);
    checkOutput("fkey_empty", {7'b0, kbdReady}, 8'h00);

    // Reset mid-frame with a character queued
    sendFrame(8'h1C);
    sendFrame(8'h32, 0, 0, 5);
    rst = 1'b1;
    waitCycles(2);
    address = 1'b1; #1;
    checkOutput("rst_kbdcr", dout, 8'h00);
    address = 1'b0; #1;
    checkOutput("rst_kbd", dout, 8'h00);
    checkOutput("rst_outputs", {5'b0, kbdReady, clrScreen, resetReq}, 8'h00);
    waitCycles(1);
    rst = 1'b0;
    waitCycles(3);
    sendFrame(8'h23);
    waitReady("post_rst_ready");
    cpuRead(1'b0, d);
    checkOutput("post_rst_read", d, 8'hC4);

    // Randomised key events against the reference model
    for (int it = 0; it < 40; it++) begin
      int r;
      logic [7:0] key;
      q = {};
      r = $urandom_range(0, 9);
      key = keyPool[$urandom_range(0, keyPool.size() - 1)];
      case (r)
        0: q = '{($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59};
        1: q = '{8'hF0, ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59};
        2: q = '{8'h14};
        3: q = '{8'hF0, 8'h14};
        4: q = '{8'hE0, 8'h5A};
        5: q = '{8'hE0, 8'h75};
        6: q = '{8'hF0, key};
        default: q = '{key};
      endcase
      foreach (q[i]) begin
        sendFrame(q[i]);
        modelFeed(q[i]);
      end
      while (expQ.size() > 0) begin
        cpuRead(1'b0, d);
        checkOutput($sformatf("rand%0d_read", it), d, expQ.pop_front());
      end
      checkOutput($sformatf("rand%0d_empty", it), {7'b0, kbdReady}, 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
